// File: rtl/retire_trace_unit_if.sv
// -----------------------------------------------------------------------------
// retire_trace_unit_if
// Valid/ready stream carrying 16-bit trace words from the retire trace unit to
// an off-core sink (trace port, UART bridge or bench monitor).
//   trc_data  : stream word, driven by the source
//   trc_valid : trc_data is valid, driven by the source
//   trc_ready : sink accepts the word, driven by the sink
// A word transfers on a rising edge where trc_valid && trc_ready.
// -----------------------------------------------------------------------------
interface retire_trace_unit_if;
    logic [15:0] trc_data;
    logic        trc_valid;
    logic        trc_ready;

    modport master (
        output trc_data,
        output trc_valid,
        input  trc_ready
    );

    modport slave (
        input  trc_data,
        input  trc_valid,
        output trc_ready
    );
endinterface

// File: rtl/retire_trace_unit.sv
// -----------------------------------------------------------------------------
// retire_trace_unit
// Samples one retire event per cycle, queues it in an event FIFO and serializes
// each event as a record of 16-bit words on a valid/ready stream.
//
// Ports:
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   retire           : an instruction completes; qualifies every event input
//   pc               : PC of the retiring instruction
//   reg_write        : register file written; write_reg / write_data
//   mem_read         : load; mem_write : store; mem_addr / mem_data
//   hlt              : halt retiring
//   trc              : trace word stream (master side)
//   overflow         : sticky, an event was dropped because the FIFO was full
//   inst_count       : number of captured events (wraps at 16 bits)
//   done             : sticky, the halt record has been fully sent
//
// Record layout: HDR = {type[2:0], reg[3:0], inum[8:0]}, then PC, then VAL
// (REGW/LOAD/STORE/HALT) and ADDR (LOAD/STORE only).
// -----------------------------------------------------------------------------
module retire_trace_unit #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       retire,
    input  logic [15:0]                pc,
    input  logic                       reg_write,
    input  logic [3:0]                 write_reg,
    input  logic [15:0]                write_data,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [15:0]                mem_addr,
    input  logic [15:0]                mem_data,
    input  logic                       hlt,
    retire_trace_unit_if.master        trc,
    output logic                       overflow,
    output logic [15:0]                inst_count,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);

    localparam logic [2:0] TYPE_REGW  = 3'b001;
    localparam logic [2:0] TYPE_LOAD  = 3'b010;
    localparam logic [2:0] TYPE_STORE = 3'b011;
    localparam logic [2:0] TYPE_OTHER = 3'b100;
    localparam logic [2:0] TYPE_HALT  = 3'b111;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_PC   = 3'd2;
    localparam logic [2:0] ST_VAL  = 3'd3;
    localparam logic [2:0] ST_ADDR = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    // Header word of a record.
    function automatic logic [15:0] hdr_word(input logic [2:0] t,
                                             input logic [3:0] r,
                                             input logic [8:0] n);
        return {t, r, n};
    endfunction

    // Event FIFO storage
    logic [2:0]    type_mem_r [DEPTH];
    logic [3:0]    reg_mem_r  [DEPTH];
    logic [8:0]    inum_mem_r [DEPTH];
    logic [15:0]   pc_mem_r   [DEPTH];
    logic [15:0]   val_mem_r  [DEPTH];
    logic [15:0]   addr_mem_r [DEPTH];

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] nxt_ptr_s;
    logic [CW-1:0] count_r;

    logic          halted_r;
    logic          overflow_r;
    logic [15:0]   inst_count_r;
    logic [15:0]   cycle_count_r;

    logic [2:0]    state_r;
    logic [15:0]   trc_data_r;
    logic          trc_valid_r;
    logic          done_r;

    logic          full_s;
    logic          cap_s;
    logic          drop_s;
    logic          xfer_s;
    logic          pop_s;
    logic [2:0]    cap_type_s;
    logic [15:0]   cap_val_s;
    logic [2:0]    head_type_s;

    logic [2:0]    state_nxt_s;
    logic [15:0]   data_nxt_s;
    logic          valid_nxt_s;
    logic          done_nxt_s;

    logic [2:0]    fin_state_s;
    logic [15:0]   fin_data_s;
    logic          fin_valid_s;
    logic          fin_done_s;

    // Fullness is judged on the registered count, so a pop on the same edge
    // cannot make room for the incoming event.
    assign full_s      = (count_r == DEPTH_C);
    assign cap_s       = retire && !halted_r && !full_s;
    assign drop_s      = retire && !halted_r && full_s;
    assign xfer_s      = trc_valid_r && trc.trc_ready;
    assign nxt_ptr_s   = rd_ptr_r + AW'(1);
    assign head_type_s = type_mem_r[rd_ptr_r];

    assign trc.trc_data  = trc_data_r;
    assign trc.trc_valid = trc_valid_r;
    assign overflow      = overflow_r;
    assign inst_count    = inst_count_r;
    assign done          = done_r;

    // Classify the retiring instruction and pick the value field it records.
    always_comb begin
        cap_type_s = TYPE_OTHER;
        if (reg_write) begin
            if (mem_read) begin
                cap_type_s = TYPE_LOAD;
            end else begin
                cap_type_s = TYPE_REGW;
            end
        end else if (hlt) begin
            cap_type_s = TYPE_HALT;
        end else if (mem_write) begin
            cap_type_s = TYPE_STORE;
        end else begin
            cap_type_s = TYPE_OTHER;
        end

        case (cap_type_s)
            TYPE_REGW, TYPE_LOAD: cap_val_s = write_data;
            TYPE_STORE:           cap_val_s = mem_data;
            TYPE_HALT:            cap_val_s = cycle_count_r;
            default:              cap_val_s = 16'h0000;
        endcase
    end

    // Write captured events into FIFO storage (no reset needed: guarded by count).
    always_ff @(posedge clk) begin
        if (cap_s) begin
            type_mem_r[wr_ptr_r] <= cap_type_s;
            reg_mem_r[wr_ptr_r]  <= write_reg;
            inum_mem_r[wr_ptr_r] <= inst_count_r[8:0];
            pc_mem_r[wr_ptr_r]   <= pc;
            val_mem_r[wr_ptr_r]  <= cap_val_s;
            addr_mem_r[wr_ptr_r] <= mem_addr;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= ZERO_C;
        end else begin
            if (cap_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= nxt_ptr_s;
            end
            case ({cap_s, pop_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // Instruction/cycle counters, halt latch and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_r      <= 1'b0;
            overflow_r    <= 1'b0;
            inst_count_r  <= 16'h0000;
            cycle_count_r <= 16'h0000;
        end else begin
            if (!halted_r) begin
                cycle_count_r <= cycle_count_r + 16'd1;
            end
            if (cap_s) begin
                inst_count_r <= inst_count_r + 16'd1;
                if (cap_type_s == TYPE_HALT) begin
                    halted_r <= 1'b1;
                end
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Decide what follows the last word of the current record. When the
    // only queued entry pops while a new event is captured, its header is
    // taken straight from the capture path to keep one word per cycle.
    always_comb begin
        if (head_type_s == TYPE_HALT) begin
            fin_state_s = ST_DONE;
            fin_data_s  = 16'h0000;
            fin_valid_s = 1'b0;
            fin_done_s  = 1'b1;
        end else if (count_r > ONE_C) begin
            fin_state_s = ST_HDR;
            fin_data_s  = hdr_word(type_mem_r[nxt_ptr_s], reg_mem_r[nxt_ptr_s],
                                   inum_mem_r[nxt_ptr_s]);
            fin_valid_s = 1'b1;
            fin_done_s  = 1'b0;
        end else if (cap_s) begin
            fin_state_s = ST_HDR;
            fin_data_s  = hdr_word(cap_type_s, write_reg, inst_count_r[8:0]);
            fin_valid_s = 1'b1;
            fin_done_s  = 1'b0;
        end else begin
            fin_state_s = ST_IDLE;
            fin_data_s  = 16'h0000;
            fin_valid_s = 1'b0;
            fin_done_s  = 1'b0;
        end
    end

    // Serializer next-state and next-word selection.
    always_comb begin
        state_nxt_s = state_r;
        data_nxt_s  = trc_data_r;
        valid_nxt_s = trc_valid_r;
        done_nxt_s  = done_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != ZERO_C) begin
                    state_nxt_s = ST_HDR;
                    data_nxt_s  = hdr_word(head_type_s, reg_mem_r[rd_ptr_r],
                                           inum_mem_r[rd_ptr_r]);
                    valid_nxt_s = 1'b1;
                end else begin
                    valid_nxt_s = 1'b0;
                end
            end
            ST_HDR: begin
                if (xfer_s) begin
                    state_nxt_s = ST_PC;
                    data_nxt_s  = pc_mem_r[rd_ptr_r];
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_PC: begin
                if (xfer_s) begin
                    if (head_type_s == TYPE_OTHER) begin
                        pop_s       = 1'b1;
                        state_nxt_s = fin_state_s;
                        data_nxt_s  = fin_data_s;
                        valid_nxt_s = fin_valid_s;
                        done_nxt_s  = fin_done_s;
                    end else begin
                        state_nxt_s = ST_VAL;
                        data_nxt_s  = val_mem_r[rd_ptr_r];
                    end
                end else begin
                    state_nxt_s = ST_PC;
                end
            end
            ST_VAL: begin
                if (xfer_s) begin
                    if ((head_type_s == TYPE_LOAD) || (head_type_s == TYPE_STORE)) begin
                        state_nxt_s = ST_ADDR;
                        data_nxt_s  = addr_mem_r[rd_ptr_r];
                    end else begin
                        pop_s       = 1'b1;
                        state_nxt_s = fin_state_s;
                        data_nxt_s  = fin_data_s;
                        valid_nxt_s = fin_valid_s;
                        done_nxt_s  = fin_done_s;
                    end
                end else begin
                    state_nxt_s = ST_VAL;
                end
            end
            ST_ADDR: begin
                if (xfer_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = fin_state_s;
                    data_nxt_s  = fin_data_s;
                    valid_nxt_s = fin_valid_s;
                    done_nxt_s  = fin_done_s;
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_DONE: begin
                valid_nxt_s = 1'b0;
                done_nxt_s  = 1'b1;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                data_nxt_s  = 16'h0000;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Serializer state and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            trc_data_r  <= 16'h0000;
            trc_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            trc_data_r  <= data_nxt_s;
            trc_valid_r <= valid_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

endmodule
